// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the pipeline hazard controller.
//   hazState_t : controller FSM states (INIT=0, RUN=1, MEM_WAIT=2, MEM_ERR=3)
//   fwdSel_t   : ALU operand forwarding selects (regfile / W result / M result)
//   RESULT_LOAD: ResultSrcE value that marks a load in E
package hazard_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    MEM_ERR  = 2'd3
  } hazState_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwdSel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: single-operand forwarding comparator.
// Ports:
//   rsE       in  5  source register of the operand in E
//   rdM       in  5  destination in M
//   regWriteM in  1  M writes the register file
//   rdW       in  5  destination in W
//   regWriteW in  1  W writes the register file
//   enable    in  1  forwarding allowed this cycle (else regfile select)
//   fwd       out 2  FWD_M / FWD_W / FWD_RF; M wins over W, x0 never forwarded
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] rsE,
  input  logic [4:0] rdM,
  input  logic       regWriteM,
  input  logic [4:0] rdW,
  input  logic       regWriteW,
  input  logic       enable,
  output logic [1:0] fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (enable && (rsE != '0)) begin
      if (regWriteM && (rdM == rsE))      fwd = FWD_M;
      else if (regWriteW && (rdW == rsE)) fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing and operand forwarding for the 5-stage
// F/D/E/M/W pipeline. Handles post-reset bubbles, load-use stalls, redirects
// and data-memory wait states with a timeout.
// Ports:
//   clk, reset (sync, active low)
//   Rs1D/Rs2D, Rs1E/Rs2E/RdE, RdM/RdW     register specifiers per stage
//   RegWriteM/RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM
//   StallF/D/E/M, FlushD/E/M/W             per-stage strobes
//   ForwardAE/ForwardBE                    operand forwarding selects
//   MemErr                                 one-cycle pulse on memory timeout
//   StallCycles/FlushEvents/MemWaitCycles  perf counters
// Optional: define HAZARD_PERF_CNT_EN to build the perf counters; otherwise
// the counter ports are tied to zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int INIT_CYC    = 2,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents,
  output logic [CNT_W-1:0] MemWaitCycles
);

  hazState_t  state, stateNext;
  logic [3:0] initCnt, initCntNext;
  logic [7:0] waitCnt, waitCntNext;
  logic       fwdEn, runRules, loadUse, memStall;

  assign loadUse  = (ResultSrcE == RESULT_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign memStall = MemReqM && !MemReadyM;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= INIT;
      initCnt <= 4'(INIT_CYC - 1);
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      initCnt <= initCntNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    initCntNext = initCnt;
    waitCntNext = waitCnt;
    fwdEn       = 1'b0;
    runRules    = 1'b0;
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushM = 1'b0; FlushW = 1'b0;
    MemErr = 1'b0;

    case (state)
      INIT: begin
        StallF = 1'b1;
        FlushD = 1'b1; FlushE = 1'b1; FlushM = 1'b1; FlushW = 1'b1;
        if (initCnt == '0) stateNext = RUN;
        else               initCntNext = initCnt - 4'd1;
      end
      RUN: begin
        fwdEn = 1'b1;
        if (memStall) begin
          StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
          FlushW = 1'b1;
          stateNext   = MEM_WAIT;
          waitCntNext = 8'd1;
        end else begin
          runRules = 1'b1;
        end
      end
      MEM_WAIT: begin
        fwdEn = 1'b1;
        if (MemReadyM) begin
          runRules    = 1'b1;
          stateNext   = RUN;
          waitCntNext = '0;
        end else begin
          StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
          FlushW = 1'b1;
          // waitCnt holds the not-ready cycles already seen (the RUN cycle
          // counts as the first); the MEM_TIMEOUT-th one triggers the abort.
          if (waitCnt >= 8'(MEM_TIMEOUT - 1)) begin
            stateNext   = MEM_ERR;
            waitCntNext = '0;
          end else begin
            waitCntNext = waitCnt + 8'd1;
          end
        end
      end
      MEM_ERR: begin
        MemErr    = 1'b1;
        FlushM    = 1'b1;
        stateNext = RUN;
      end
      default: stateNext = INIT;
    endcase

    // Redirect beats load-use: the D instruction is flushed, so holding it
    // (and F) would be pointless.
    if (runRules) begin
      if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (loadUse) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  fwd_sel uFwdA (
    .rsE(Rs1E), .rdM(RdM), .regWriteM(RegWriteM),
    .rdW(RdW), .regWriteW(RegWriteW), .enable(fwdEn), .fwd(ForwardAE)
  );

  fwd_sel uFwdB (
    .rsE(Rs2E), .rdM(RdM), .regWriteM(RegWriteM),
    .rdW(RdW), .regWriteW(RegWriteW), .enable(fwdEn), .fwd(ForwardBE)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt, flushCnt, waitCyc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
      waitCyc  <= '0;
    end else if (state != INIT) begin
      if (StallF && (stallCnt != '1))          stallCnt <= stallCnt + CNT_W'(1);
      if (FlushE && (flushCnt != '1))          flushCnt <= flushCnt + CNT_W'(1);
      if ((state == MEM_WAIT) && (waitCyc != '1)) waitCyc <= waitCyc + CNT_W'(1);
    end
  end

  assign StallCycles   = stallCnt;
  assign FlushEvents   = flushCnt;
  assign MemWaitCycles = waitCyc;
`else
  assign StallCycles   = '0;
  assign FlushEvents   = '0;
  assign MemWaitCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl instances (MEM_TIMEOUT 8 and 4) share one
// stimulus stream; a behavioural model tracks cycles since reset and the run
// of consecutive not-ready memory cycles and predicts every strobe.
module tb_hazard_ctrl;

  localparam int INIT_CYC = 2;
  localparam int CNT_W    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ResultSrcE;

  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MemErr;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] StallCycles, FlushEvents, MemWaitCycles;

  logic StallFB, StallDB, StallEB, StallMB, FlushDB, FlushEB, FlushMB, FlushWB, MemErrB;
  logic [1:0] ForwardAEB, ForwardBEB;
  logic [CNT_W-1:0] StallCyclesB, FlushEventsB, MemWaitCyclesB;

  hazard_ctrl #(.INIT_CYC(INIT_CYC), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dutA (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemErr(MemErr),
    .StallCycles(StallCycles), .FlushEvents(FlushEvents), .MemWaitCycles(MemWaitCycles)
  );

  hazard_ctrl #(.INIT_CYC(INIT_CYC), .MEM_TIMEOUT(4), .CNT_W(CNT_W)) dutB (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallFB), .StallD(StallDB), .StallE(StallEB), .StallM(StallMB),
    .FlushD(FlushDB), .FlushE(FlushEB), .FlushM(FlushMB), .FlushW(FlushWB),
    .ForwardAE(ForwardAEB), .ForwardBE(ForwardBEB), .MemErr(MemErrB),
    .StallCycles(StallCyclesB), .FlushEvents(FlushEventsB), .MemWaitCycles(MemWaitCyclesB)
  );

  int checks   = 0;
  int failures = 0;

  // Model state per instance: cycles since reset, consecutive not-ready count,
  // error-pulse-due flag, timeout value. Perf tallies for instance A only.
  int since [2];
  int consec[2];
  bit errNow[2];
  int tmo   [2] = '{8, 4};
  int pStall, pFlush, pWait;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwdRule(input logic [4:0] rs);
    if (rs != 0 && RegWriteM && RdM == rs) return 2'b10;
    if (rs != 0 && RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Bit order: StallF StallD StallE StallM FlushD FlushE FlushM FlushW MemErr
  function automatic logic [8:0] expStrobes(input int i);
    logic [8:0] s;
    bit lu;
    s  = '0;
    lu = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
    if (since[i] < INIT_CYC)                          s = 9'b1000_1111_0;
    else if (errNow[i])                               s = 9'b0000_0010_1;
    else if (!MemReadyM && (consec[i] > 0 || MemReqM)) s = 9'b1111_0001_0;
    else if (PCSrcE)                                  s = 9'b0000_1100_0;
    else if (lu)                                      s = 9'b1100_0100_0;
    return s;
  endfunction

  function automatic logic [3:0] expFwd(input int i);
    if (since[i] < INIT_CYC) return 4'b0000;
    return {fwdRule(Rs1E), fwdRule(Rs2E)};
  endfunction

  task automatic checkOutputs();
    checkVal("strobesA", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW, MemErr},
             expStrobes(0));
    checkVal("strobesB", {StallFB, StallDB, StallEB, StallMB, FlushDB, FlushEB, FlushMB, FlushWB, MemErrB},
             expStrobes(1));
    if (!errNow[0]) checkVal("fwdA", {ForwardAE, ForwardBE}, expFwd(0));
    if (!errNow[1]) checkVal("fwdB", {ForwardAEB, ForwardBEB}, expFwd(1));
  endtask

  task automatic modelEdge(input int i);
    logic [8:0] s;
    bit inInit, mem;
    if (!reset) begin
      since[i] = 0; consec[i] = 0; errNow[i] = 1'b0;
      if (i == 0) begin pStall = 0; pFlush = 0; pWait = 0; end
      return;
    end
    s      = expStrobes(i);
    inInit = since[i] < INIT_CYC;
    mem    = !MemReadyM && (consec[i] > 0 || MemReqM);
    if (i == 0 && !inInit) begin
      if (s[8]) pStall++;
      if (s[3]) pFlush++;
      if (!errNow[i] && consec[i] > 0) pWait++;
    end
    if (since[i] < 1000000) since[i]++;
    if (inInit) consec[i] = 0;
    else if (errNow[i]) begin errNow[i] = 1'b0; consec[i] = 0; end
    else if (mem) begin
      consec[i]++;
      if (consec[i] == tmo[i]) begin errNow[i] = 1'b1; consec[i] = 0; end
    end else consec[i] = 0;
  endtask

  task automatic checkCounters();
`ifdef HAZARD_PERF_CNT_EN
    checkVal("StallCycles", StallCycles, pStall);
    checkVal("FlushEvents", FlushEvents, pFlush);
    checkVal("MemWaitCycles", MemWaitCycles, pWait);
`else
    checkVal("StallCycles", StallCycles, 0);
    checkVal("FlushEvents", FlushEvents, 0);
    checkVal("MemWaitCycles", MemWaitCycles, 0);
`endif
  endtask

  // Inputs are set just after a rising edge; outputs are sampled on the
  // falling edge; the model advances on the following rising edge.
  task automatic step();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    modelEdge(0);
    modelEdge(1);
    #1;
    checkCounters();
  endtask

  task automatic idle();
    Rs1D = 5'd1; Rs2D = 5'd2; Rs1E = 5'd3; Rs2E = 5'd4; RdE = 5'd9; RdM = 5'd10; RdW = 5'd11;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemReadyM = 1'b1;
  endtask

  task automatic doReset(input int lowCycles);
    reset = 1'b0;
    repeat (lowCycles) step();
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clk);
    modelEdge(0); modelEdge(1);
    #1;

    // Reset low, then INIT bubbles, then quiet RUN.
    doReset(3);
    repeat (INIT_CYC + 2) step();

    // Load-use on x5, then the same with x0 as destination.
    ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5; step();
    idle(); step();
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; step();
    idle(); step();

    // Forwarding priority and x0.
    RdM = 5'd7; RegWriteM = 1'b1; RdW = 5'd7; RegWriteW = 1'b1; Rs1E = 5'd7; step();
    RegWriteM = 1'b0; step();
    RegWriteM = 1'b1; RdM = 5'd0; Rs2E = 5'd0; step();
    idle(); step();

    // Counter scenario: fresh reset, 3 load-use stalls, 5-cycle wait with a
    // pending redirect, release. Instance B times out during the wait.
    doReset(1);
    repeat (INIT_CYC) step();
    for (int k = 0; k < 3; k++) begin
      ResultSrcE = 2'b01; RdE = 5'd6; Rs2D = 5'd6; step();
      idle(); step();
    end
    MemReqM = 1'b1; MemReadyM = 1'b0; PCSrcE = 1'b1;
    repeat (5) step();
    MemReadyM = 1'b1; step();
    idle(); step();
`ifdef HAZARD_PERF_CNT_EN
    checkVal("StallCycles_scn", StallCycles, 8);
    checkVal("MemWaitCycles_scn", MemWaitCycles, 5);
    checkVal("FlushEvents_scn", FlushEvents, 4);
`else
    checkVal("StallCycles_scn", StallCycles, 0);
    checkVal("MemWaitCycles_scn", MemWaitCycles, 0);
`endif

    // Randomized traffic with occasional mid-run resets and slow-memory bursts.
    for (int n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(0, 249) != 0);
      Rs1D       = 5'($urandom_range(0, 3));
      Rs2D       = 5'($urandom_range(0, 3));
      Rs1E       = 5'($urandom_range(0, 3));
      Rs2E       = 5'($urandom_range(0, 3));
      RdE        = 5'($urandom_range(0, 3));
      RdM        = 5'($urandom_range(0, 3));
      RdW        = 5'($urandom_range(0, 3));
      RegWriteM  = 1'($urandom_range(0, 1));
      RegWriteW  = 1'($urandom_range(0, 1));
      ResultSrcE = 2'($urandom_range(0, 3));
      PCSrcE     = ($urandom_range(0, 3) == 0);
      MemReqM    = ($urandom_range(0, 2) == 0);
      MemReadyM  = ((n / 64) % 3 == 2) ? ($urandom_range(0, 7) == 0)
                                       : ($urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
